spi_master_core: RTL
====================

// Module: spi_master_core
// PURPOSE
//  Single-clock SPI master engine: serializes one G_DATA_WIDTH word on mosi while
//  capturing miso, with configurable CPOL/CPHA, bit order and SCLK divider.
//  It is the DUT stage driven by the SPI master library testbench. Its set/wait/check
//  modules drive start/tx_data, and its checkers consume rx_data/rx_valid and the SPI pins.
// PARAMETERS
//  G_DATA_WIDTH  8  bits per transfer (>=2)
//  G_CLK_DIV     4  clk cycles per SCLK half-period (>=1)
//  G_CPOL        0  SCLK idle level
//  G_CPHA        0  0: sample leading edge, shift trailing; 1: shift leading, sample trailing
//  G_MSB_FIRST   1  1: MSB first on mosi and miso; 0: LSB first
// PORTS
//  clk       in   1             system clock, all logic on rising edge
//  rst       in   1             synchronous reset, active-high
//  start     in   1             transfer request, sampled only when busy=0
//  tx_data   in   G_DATA_WIDTH  word to send, latched on accepted start
//  rx_data   out  G_DATA_WIDTH  last received word, stable until next rx_valid
//  rx_valid  out  1             one-cycle pulse: rx_data updated, transfer complete
//  busy      out  1             high from cycle after accept until transfer complete
//  sclk      out  1             SPI clock
//  mosi      out  1             SPI master-out
//  miso      in   1             SPI master-in, sampled directly (no synchronizer)
//  cs_n      out  1             SPI chip select, active-low
// BEHAVIOUR
//  - Reset (sync, priority over all): state=IDLE, sclk=G_CPOL, cs_n=1, mosi=0, busy=0,
//    rx_valid=0, rx_data=0, counters=0. Mid-transfer reset aborts: no rx_valid, no rx_data update.
//  - All outputs registered. FSM states: IDLE -> CS_SETUP -> TRANSFER -> CS_HOLD -> IDLE.
//  - IDLE: busy=0, cs_n=1, sclk=G_CPOL. start=1 at edge T: latch tx_data into shift reg,
//    go to CS_SETUP. From T+1: cs_n=0 and busy=1. mosi=first bit (MSB if G_MSB_FIRST).
//  - CS_SETUP: G_CLK_DIV cycles, sclk idle, then TRANSFER.
//  - TRANSFER: 2*G_DATA_WIDTH SCLK edges, one every G_CLK_DIV cycles; divider counter
//    0..G_CLK_DIV-1 wraps, edge counter 0..2*G_DATA_WIDTH-1.
//    CPHA=0: first bit on mosi before first edge; odd (leading) edges sample miso,
//      even (trailing) edges shift next bit out. No shift after last trailing edge.
//    CPHA=1: leading edges shift next bit out (first leading edge drives bit 0 of order);
//      trailing edges sample miso.
//    miso bits assembled in bit order matching G_MSB_FIRST.
//  - After the final edge, sclk=G_CPOL. CS_HOLD lasts G_CLK_DIV cycles, then IDLE.
//  - Entry to IDLE in the same cycle: cs_n=1, busy=0, rx_valid=1, rx_data=received word.
//  - Back-to-back: start may be accepted in the rx_valid cycle. cs_n then stays high
//    for exactly 1 cycle.
//  - start while busy=1 is ignored: no queueing, tx_data changes ignored.
//  - cs_n low duration = (2*G_DATA_WIDTH+2)*G_CLK_DIV cycles. Accept->rx_valid latency
//    = that +1 cycles (W=8, D=4: 72 low, rx_valid at T+73).
//  - mosi holds last driven bit while cs_n=1. Bus-turnaround and miso tristate are out of scope.
// TESTING
//  1 Mode0, W=8, D=4, MSB first, miso looped to mosi, tx 0xA5 -> rx_data=0xA5, rx_valid at
//    T+73, 8 leading edges, cs_n low 72 cycles, sclk idle 0.
//  2 CPOL=1 CPHA=1, slave model drives 0x3C on shift edges, tx 0xC3 -> rx_data=0x3C,
//    model captures 0xC3, sclk idles high before and after.
//  3 LSB first, tx 0x01 -> first mosi bit 1 followed by seven 0; loopback rx_data=0x01.
//  4 Start held high continuously, tx 0x11 then 0x22 -> two transfers, cs_n high exactly 1
//    cycle between, two rx_valid pulses carrying 0x11 and 0x22.
//  5 Pulse start again at edge 5 of transfer -> ignored, one rx_valid only.
//    Assert rst at edge 7 -> next cycle cs_n=1, sclk=CPOL, busy=0, rx_data=0, no rx_valid.
//  6 D=1 boundary, tx 0xFF with miso=0 -> sclk toggles every clk, rx_data=0x00,
//    cs_n low 18 cycles.

Source files
------------

// File: rtl/spi_master_core_if.sv
// Handshake and SPI pin bundle for spi_master_core.
// The master modport is the core's view. The slave modport is the view of
// whatever drives requests and the miso line.
interface spi_master_core_if #(
  parameter int G_DATA_WIDTH = 8
) ();

  logic                    start;
  logic [G_DATA_WIDTH-1:0] tx_data;
  logic [G_DATA_WIDTH-1:0] rx_data;
  logic                    rx_valid;
  logic                    busy;
  logic                    sclk;
  logic                    mosi;
  logic                    miso;
  logic                    cs_n;

  modport master (
    input  start, tx_data, miso,
    output rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

endinterface

// File: rtl/spi_master_core.sv
// Single-clock SPI master engine.
// Sends one G_DATA_WIDTH word on mosi and captures miso in the same transfer.
// CPOL, CPHA, bit order and the SCLK divider are set by parameters.
// Sequence: IDLE -> CS_SETUP -> TRANSFER -> CS_HOLD -> IDLE.
// Every output is a register.
module spi_master_core #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_CLK_DIV    = 4,
  parameter bit G_CPOL       = 1'b0,
  parameter bit G_CPHA       = 1'b0,
  parameter bit G_MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_core_if.master bus
);

  localparam int W      = G_DATA_WIDTH;
  localparam int DIV_W  = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(G_CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    TRANSFER,
    CS_HOLD
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [W-1:0]      tx_shift;
  logic [W-1:0]      rx_shift;

  logic              div_wrap;
  logic              leading;
  logic              last_edge;
  logic              first_bit;
  logic              tx_head;
  logic              tx_next_head;
  logic [W-1:0]      tx_shifted;
  logic [W-1:0]      rx_captured;

  // Decode the divider and edge position.
  // Also form the bit-order dependent shift and capture values.
  // NOTE: every signal gets a value on every path through this block; any
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    div_wrap  = (div_cnt == DIV_LAST);
    leading   = ~edge_cnt[0];
    last_edge = (edge_cnt == EDGE_LAST);
    if (G_MSB_FIRST) begin
      first_bit    = bus.tx_data[W-1];
      tx_head      = tx_shift[W-1];
      tx_next_head = tx_shift[W-2];
      tx_shifted   = {tx_shift[W-2:0], 1'b0};
      rx_captured  = {rx_shift[W-2:0], bus.miso};
    end else begin
      first_bit    = bus.tx_data[0];
      tx_head      = tx_shift[0];
      tx_next_head = tx_shift[1];
      tx_shifted   = {1'b0, tx_shift[W-1:1]};
      rx_captured  = {bus.miso, rx_shift[W-1:1]};
    end
  end

  // Transfer sequencer.
  // Owns the state, counters and shift registers, and drives every output
  // register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bus.sclk     <= G_CPOL;
      bus.cs_n     <= 1'b1;
      bus.mosi     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx_shift <= bus.tx_data;
            rx_shift <= '0;
            bus.mosi <= first_bit;
            bus.cs_n <= 1'b0;
            bus.busy <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            state   <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        TRANSFER: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            bus.sclk <= ~bus.sclk;
            if (leading ^ G_CPHA) begin
              // Sampling edge: leading when CPHA=0, trailing when CPHA=1.
              rx_shift <= rx_captured;
            end else if (!G_CPHA) begin
              // CPHA=0 trailing edge: present the next bit.
              // Skip this after the final edge.
              if (!last_edge) begin
                bus.mosi <= tx_next_head;
                tx_shift <= tx_shifted;
              end
            end else begin
              // CPHA=1 leading edge: drive the current head bit, then advance.
              bus.mosi <= tx_head;
              tx_shift <= tx_shifted;
            end
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= CS_HOLD;
            end else begin
              edge_cnt <= edge_cnt + EDGE_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CS_HOLD: begin
          if (div_wrap) begin
            div_cnt      <= '0;
            bus.cs_n     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.rx_valid <= 1'b1;
            bus.rx_data  <= rx_shift;
            state        <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
